// File: rtl/i2c_arb_pkg.sv
// Shared types for the codec I2C request arbiter.
// Arbiter FSM states, payload width and transfer result codes.
package i2c_arb_pkg;

    localparam int I2C_WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } arb_state_e;

    typedef enum logic {
        RES_DONE,
        RES_NACK
    } arb_res_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: first set request at or after ptr.
// Purely combinational; reusable for any shared resource.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    int k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!vld_o && req_i[IDX_W'(k)]) begin
                vld_o               = 1'b1;
                gnt_o[IDX_W'(k)]    = 1'b1;
                idx_o               = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one codec I2C master between N_REQ requesters, round-robin.
// One start pulse per grant; one done/nack pulse back to the winner.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int WORD_W      = I2C_WORD_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk_i2c,
    input  logic                    reg_rstn,
    input  logic                    en_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*WORD_W-1:0] data_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [N_REQ-1:0]        done_o,
    output logic [N_REQ-1:0]        nack_o,
    output logic                    send_start_o,
    output logic [WORD_W-1:0]       i2c_data_o,
    input  logic                    i2c_busy_i,
    input  logic                    i2c_done_i,
    output logic                    arb_busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    arb_state_e         state_q, state_d;
    arb_res_e           res_q, res_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_idx_q, win_idx_d;
    logic [N_REQ-1:0]   win_oh_q, win_oh_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    always_ff @(posedge clk_i2c or negedge reg_rstn) begin
        if (!reg_rstn) begin
            state_q   <= IDLE;
            res_q     <= RES_DONE;
            ptr_q     <= '0;
            win_idx_q <= '0;
            win_oh_q  <= '0;
            word_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            win_oh_q  <= win_oh_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        win_oh_d  = win_oh_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (en_i && pick_vld && !i2c_busy_i) begin
                    win_idx_d = pick_idx;
                    win_oh_d  = pick_gnt;
                    word_d    = data_i[pick_idx*WORD_W +: WORD_W];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A fast master may finish before busy is ever seen.
                if (i2c_done_i) begin
                    res_d   = RES_DONE;
                    state_d = RESP;
                end else if (i2c_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    res_d   = RES_NACK;
                    state_d = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (i2c_done_i) begin
                    res_d   = RES_DONE;
                    state_d = RESP;
                end else if (!i2c_busy_i) begin
                    res_d   = RES_NACK;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = (win_idx_q == IDX_W'(N_REQ - 1)) ?
                          '0 : win_idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign arb_busy_o   = (state_q != IDLE);
    assign gnt_o        = arb_busy_o ? win_oh_q : '0;
    assign send_start_o = (state_q == ISSUE);
    assign i2c_data_o   = word_q;
    assign done_o       = (state_q == RESP && res_q == RES_DONE) ?
                          win_oh_q : '0;
    assign nack_o       = (state_q == RESP && res_q == RES_NACK) ?
                          win_oh_q : '0;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized bench for i2c_req_arbiter against a transaction-level model.
// Model predicts winner by round-robin rule and response cycle by arithmetic.
module tb_i2c_req_arbiter;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int TO = 64;

    localparam int M_ACK  = 0;
    localparam int M_SIM  = 1;
    localparam int M_NACK = 2;
    localparam int M_FAST = 3;
    localparam int M_TO   = 4;

    logic           clk_i2c = 1'b0;
    logic           reg_rstn;
    logic           en_i;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   gnt_o, done_o, nack_o;
    logic           send_start_o;
    logic [W-1:0]   i2c_data_o;
    logic           i2c_busy_i, i2c_done_i;
    logic           arb_busy_o;

    logic [W-1:0]   words [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign data_i[g*W +: W] = words[g];
    end

    always #5 clk_i2c = ~clk_i2c;

    i2c_req_arbiter #(
        .N_REQ       (N),
        .WORD_W      (W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i2c      (clk_i2c),
        .reg_rstn     (reg_rstn),
        .en_i         (en_i),
        .req_i        (req_i),
        .data_i       (data_i),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .nack_o       (nack_o),
        .send_start_o (send_start_o),
        .i2c_data_o   (i2c_data_o),
        .i2c_busy_i   (i2c_busy_i),
        .i2c_done_i   (i2c_done_i),
        .arb_busy_o   (arb_busy_o)
    );

    int           n_chk  = 0;
    int           n_fail = 0;
    int           ptr_m  = 0;
    logic [N-1:0] req_m  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int rr_model(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_gnt"},   gnt_o,        '0);
        check_eq({tag, "_start"}, send_start_o, 1'b0);
        check_eq({tag, "_done"},  done_o,       '0);
        check_eq({tag, "_nack"},  nack_o,       '0);
        check_eq({tag, "_busy"},  arb_busy_o,   1'b0);
    endtask

    task automatic run_txn(input int mode, input int b, input int e,
                           input bit drop, output int win);
        int           resp;
        logic [W-1:0] wexp;
        logic [N-1:0] won;
        bit           is_nack;
        if (req_m == '0) req_m[0] = 1'b1;
        win     = rr_model(req_m, ptr_m);
        won     = onehot(win);
        wexp    = words[win];
        is_nack = (mode == M_NACK) || (mode == M_TO);
        resp    = (mode == M_TO) ? TO + 1 : e + 1;
        en_i       = 1'b1;
        i2c_busy_i = 1'b0;
        i2c_done_i = 1'b0;
        req_i      = req_m;
        for (int c = 0; c <= resp; c++) begin
            @(negedge clk_i2c);
            check_eq("gnt", gnt_o, won);
            check_eq("start", send_start_o, c == 0);
            check_eq("data", i2c_data_o, wexp);
            check_eq("arb_busy", arb_busy_o, 1'b1);
            check_eq("done", done_o,
                     (c == resp && !is_nack) ? won : '0);
            check_eq("nack", nack_o,
                     (c == resp && is_nack) ? won : '0);
            i2c_busy_i = 1'b0;
            i2c_done_i = 1'b0;
            case (mode)
                M_ACK: begin
                    i2c_busy_i = (c >= b && c <= e);
                    i2c_done_i = (c == e);
                end
                M_SIM: begin
                    i2c_busy_i = (c >= b && c < e);
                    i2c_done_i = (c == e);
                end
                M_NACK: i2c_busy_i = (c >= b && c < e);
                M_FAST: i2c_done_i = (c == e);
                default: ;
            endcase
            en_i = 1'($urandom);
            for (int k = 0; k < N; k++) begin
                words[k] = W'($urandom);
                if (k != win && !req_m[k])
                    req_m[k] = ($urandom_range(0, 7) == 0);
            end
            if ((drop && c >= 1) || c == resp) req_m[win] = 1'b0;
            req_i = req_m;
        end
        @(negedge clk_i2c);
        check_quiet("post");
        ptr_m = (win + 1) % N;
    endtask

    task automatic idle_block();
        en_i       = 1'b0;
        i2c_busy_i = 1'b0;
        req_i      = req_m;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i2c);
            check_quiet("en_low");
        end
        en_i       = 1'b1;
        i2c_busy_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i2c);
            check_quiet("ext_busy");
        end
        i2c_busy_i = 1'b0;
    endtask

    task automatic reset_mid();
        int win;
        req_m      = 2'b11;
        win        = rr_model(req_m, ptr_m);
        en_i       = 1'b1;
        i2c_busy_i = 1'b0;
        i2c_done_i = 1'b0;
        req_i      = req_m;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk_i2c);
            check_eq("rst_pre_gnt", gnt_o, onehot(win));
            i2c_busy_i = (c >= 2);
        end
        reg_rstn = 1'b0;
        #1;
        check_quiet("rst_mid");
        check_eq("rst_mid_data", i2c_data_o, '0);
        en_i       = 1'b0;
        i2c_busy_i = 1'b0;
        @(negedge clk_i2c);
        check_quiet("rst_hold");
        reg_rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i2c);
            check_quiet("rst_after");
        end
        ptr_m = 0;
    endtask

    initial begin
        int win;
        int b, e, mode;
        reg_rstn   = 1'b0;
        en_i       = 1'b0;
        req_i      = '0;
        i2c_busy_i = 1'b0;
        i2c_done_i = 1'b0;
        for (int k = 0; k < N; k++) words[k] = '0;
        @(negedge clk_i2c);
        #1;
        check_quiet("reset");
        check_eq("reset_data", i2c_data_o, '0);
        @(negedge clk_i2c);
        reg_rstn = 1'b1;

        // Contention from reset: both held, four back-to-back transfers.
        for (int i = 0; i < 4; i++) begin
            req_m = 2'b11;
            b = $urandom_range(1, 4);
            run_txn(M_ACK, b, b + $urandom_range(1, 10), 1'b0, win);
        end

        // Single request: busy 2 cycles after start, done 20 later.
        req_m    = 2'b01;
        words[0] = 16'h0c10;
        run_txn(M_ACK, 2, 22, 1'b0, win);

        req_m = 2'b11;
        run_txn(M_NACK, 3, 10, 1'b0, win);
        run_txn(M_ACK, 1, 5, 1'b0, win);
        run_txn(M_TO, 0, 0, 1'b0, win);
        req_m = 2'b11;
        run_txn(M_SIM, 2, 9, 1'b0, win);
        run_txn(M_FAST, 0, 3, 1'b1, win);

        req_m = 2'b10;
        idle_block();

        req_m = 2'b01;
        run_txn(M_ACK, 1, 4, 1'b0, win);
        reset_mid();
        run_txn(M_ACK, 2, 6, 1'b0, win);

        for (int i = 0; i < 40; i++) begin
            req_m = req_m | N'($urandom);
            mode  = $urandom_range(0, 4);
            b     = $urandom_range(1, 5);
            e     = b + $urandom_range(1, 25);
            run_txn(mode, b, e, ($urandom_range(0, 3) == 0), win);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares the single codec I2C master between N requesters, for example the boot-time codec configuration sequencer and run-time volume/mute updaters.
- Accepts a 16-bit codec register word from each requester and grants them round-robin.
- Issues one start pulse per grant to the I2C master and monitors its busy/done handshake.
- Returns a one-cycle done or nack pulse to the granted requester.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- WORD_W, 16, I2C payload width (7-bit register address + 9-bit data).
- TIMEOUT_CYC, 64, clk_i2c cycles to wait for i2c_busy_i to rise after a start pulse before declaring nack.

Ports:
- clk_i2c  in  1  I2C-domain clock.
- reg_rstn  in  1  asynchronous active-low reset.
- en_i  in  1  arbitration enable; low blocks new grants only.
- req_i  in  N_REQ  per-requester level request; held until that requester's done_o/nack_o.
- data_i  in  N_REQ*WORD_W  packed words; requester k occupies bits [k*WORD_W +: WORD_W].
- gnt_o  out  N_REQ  one-hot grant, high from ISSUE through RESP.
- done_o  out  N_REQ  one-cycle pulse: transfer acknowledged.
- nack_o  out  N_REQ  one-cycle pulse: transfer failed (nack or timeout).
- send_start_o  out  1  one-cycle start pulse to the I2C master.
- i2c_data_o  out  WORD_W  word latched at grant; stable ISSUE..RESP.
- i2c_busy_i  in  1  I2C master busy.
- i2c_done_i  in  1  I2C master transfer-complete pulse (ack received).
- arb_busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset: reset reg_rstn, asynchronous, active-low; clock clk_i2c.
  - While reset is low, all outputs are 0, the state is IDLE, the round-robin pointer is 0, and the timeout counter is 0.
  - Reset asserted mid-transfer aborts the transfer immediately and no response pulse is issued.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - If en_i && |req_i && ~i2c_busy_i at edge t, choose the winner as the first set req bit at or after ptr, wrapping modulo N_REQ.
  - At that edge, latch the winner's index and word; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly one cycle):
  - send_start_o=1, gnt_o[win]=1.
  - Go to WAIT_BUSY with the counter cleared.
  - Latency: request sampled at edge t gives send_start_o high during cycle t+1.
- WAIT_BUSY:
  - If i2c_busy_i=1, go to WAIT_DONE.
  - Else the counter increments; when counter==TIMEOUT_CYC-1, set result=nack and go to RESP.
  - If i2c_done_i=1 is seen here, set result=done and go to RESP (this covers a fast master).
- WAIT_DONE:
  - If i2c_done_i=1, set result=done and go to RESP.
  - Else if i2c_busy_i=0, set result=nack and go to RESP.
  - If i2c_done_i and the busy fall occur in the same cycle, done wins.
- RESP (exactly one cycle):
  - done_o[win] or nack_o[win] pulses high; gnt_o[win] stays high.
  - ptr <= (win+1) mod N_REQ; go to IDLE.
  - A new grant is possible no earlier than the cycle after RESP.
- en_i low never aborts an in-flight transfer; it only holds the block in IDLE.
- A requester that drops req_i mid-transfer still receives its response pulse; the transfer is not cancelled.
- Requests arriving during a transfer wait in IDLE for arbitration; no request is lost while held.
- At most one bit of gnt_o, done_o or nack_o is high in any cycle; done_o and nack_o are never both high.
- Counter width: $clog2(TIMEOUT_CYC)+1; it saturates and does not wrap.

Decomposition:
- Package i2c_arb_pkg holds:
  - the arb_state_e enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP);
  - I2C_WORD_W = 16;
  - the result enum (RES_DONE, RES_NACK).
- Sub-module rr_pick: purely combinational next-winner logic from req and ptr. It outputs a one-hot grant and a binary index and is reusable for other shared resources.
- The FSM, latches and counter stay in the top module.

Test Plan:
- Single request: N_REQ=2, req_i=2'b01, data 16'h0c10; the master raises busy 2 cycles after start and pulses done 20 cycles later. Required: send_start_o for 1 cycle one cycle after the request, i2c_data_o=16'h0c10, then done_o=2'b01 for 1 cycle.
- Contention: both requesters hold req from reset with ptr=0. Required: grant order 0,1,0,1 over four transfers, with a done pulse to the correct index each time.
- Nack: during WAIT_DONE, busy falls with no i2c_done_i. Required: nack_o[win]=1 for 1 cycle, ptr advances, and the next requester is served.
- Timeout: busy never rises after start, TIMEOUT_CYC=64. Required: nack_o pulses exactly 64 cycles after leaving ISSUE.
- Simultaneous done and busy fall in the same cycle: required done_o, not nack_o. Separately, i2c_done_i seen in WAIT_BUSY: required done_o.
- Reset mid-transfer: reg_rstn pulsed low in WAIT_DONE. Required: all outputs 0 immediately, no response pulse, ptr=0. A held request is re-granted after release.
